// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the multi-lane dot-product PE.
// Latency: n/a (package). Backpressure: n/a.
// PE_SATURATE_EN selects clamping instead of wrap in the MAC lanes via sat_add.
package pe_pkg;

    typedef enum logic [1:0] {
        PE_IDLE    = 2'd0,
        PE_COMPUTE = 2'd1,
        PE_RESULT  = 2'd2
    } pe_state_t;

    // Wide enough to hold any accumulator sum exactly, so range checks never wrap.
    localparam int PE_WIDE = 64;

    function automatic logic signed [PE_WIDE-1:0] ACC_MAX(input int w);
        logic signed [PE_WIDE-1:0] one;
        one = PE_WIDE'(1);
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [PE_WIDE-1:0] ACC_MIN(input int w);
        logic signed [PE_WIDE-1:0] one;
        one = PE_WIDE'(1);
        return -(one <<< (w - 1));
    endfunction

    function automatic logic signed [PE_WIDE-1:0] sat_add(
        input logic signed [PE_WIDE-1:0] a,
        input logic signed [PE_WIDE-1:0] b,
        input int                        w
    );
        logic signed [PE_WIDE-1:0] s;
        s = a + b;
        if (s > ACC_MAX(w)) begin
            return ACC_MAX(w);
        end else if (s < ACC_MIN(w)) begin
            return ACC_MIN(w);
        end
        return s;
    endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// One signed MAC lane with sticky overflow flag; wraps, or clamps under PE_SATURATE_EN.
// Latency: accumulator updates on the edge where en is high; clr has priority.
// Backpressure: none, the caller gates en with its handshake.
module pe_mac_lane
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ACCUM_WIDTH = 35
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          en,
    input  logic signed [DATA_WIDTH-1:0]  in1,
    input  logic signed [DATA_WIDTH-1:0]  in2,
    output logic signed [ACCUM_WIDTH-1:0] acc,
    output logic                          err
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic signed [PE_WIDE-1:0] MAX_W = ACC_MAX(ACCUM_WIDTH);
    localparam logic signed [PE_WIDE-1:0] MIN_W = ACC_MIN(ACCUM_WIDTH);

    logic signed [PROD_W-1:0]  prod;
    logic signed [PE_WIDE-1:0] acc_w;
    logic signed [PE_WIDE-1:0] prod_w;
    logic signed [PE_WIDE-1:0] sum_w;
    logic signed [PE_WIDE-1:0] next_w;
    logic                      ovf;

    assign prod = $signed({{DATA_WIDTH{in1[DATA_WIDTH-1]}}, in1})
                * $signed({{DATA_WIDTH{in2[DATA_WIDTH-1]}}, in2});

    assign acc_w  = {{(PE_WIDE-ACCUM_WIDTH){acc[ACCUM_WIDTH-1]}}, acc};
    assign prod_w = {{(PE_WIDE-PROD_W){prod[PROD_W-1]}}, prod};
    // Exact sum in the wide domain; overflow means it left the accumulator's range.
    assign sum_w  = acc_w + prod_w;
    assign ovf    = (sum_w > MAX_W) || (sum_w < MIN_W);

`ifdef PE_SATURATE_EN
    assign next_w = sat_add(acc_w, prod_w, ACCUM_WIDTH);
`else
    assign next_w = sum_w;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            err <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            err <= 1'b0;
        end else if (en) begin
            acc <= next_w[ACCUM_WIDTH-1:0];
            if (ovf) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_multilane.sv
// Multi-lane dot-product PE: row buffer of A times LANES columns of B, runtime length K.
// Latency: totals valid the cycle after the last accepted beat (K+1 from start); PE_SATURATE_EN clamps.
// Backpressure: col_ready only in COMPUTE; results held in RESULT until res_ready.
module pe_multilane
    import pe_pkg::*;
#(
    parameter int P           = 8,
    parameter int LANES       = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ACCUM_WIDTH = 2 * DATA_WIDTH + $clog2(P),
    parameter int P_WIDTH     = (P <= 1) ? 1 : $clog2(P),
    parameter int LEN_WIDTH   = $clog2(P + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load_row,
    input  logic [P*DATA_WIDTH-1:0]        row,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           len,
    input  logic                           col_valid,
    output logic                           col_ready,
    input  logic [LANES*DATA_WIDTH-1:0]    col_data,
    output logic [P_WIDTH-1:0]             p,
    output logic                           busy,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [LANES*ACCUM_WIDTH-1:0]   total,
    output logic [LANES-1:0]               err
);

    localparam logic [LEN_WIDTH-1:0] P_LEN = LEN_WIDTH'(P);

    pe_state_t                 state_q;
    pe_state_t                 state_d;
    logic [DATA_WIDTH-1:0]     row_buf [P];
    logic [LEN_WIDTH-1:0]      klat;
    logic [LEN_WIDTH-1:0]      len_clamped;
    logic                      last_beat;
    logic                      lane_clr;
    logic                      lane_en;

    assign len_clamped = (len > P_LEN) ? P_LEN : len;
    assign last_beat   = (LEN_WIDTH'(p) == (klat - LEN_WIDTH'(1)));
    assign busy        = (state_q != PE_IDLE);

    always_comb begin
        state_d   = state_q;
        col_ready = 1'b0;
        res_valid = 1'b0;
        lane_clr  = 1'b0;
        lane_en   = 1'b0;
        case (state_q)
            PE_IDLE: begin
                if (start) begin
                    lane_clr = 1'b1;
                    state_d  = (len == '0) ? PE_RESULT : PE_COMPUTE;
                end
            end
            PE_COMPUTE: begin
                col_ready = 1'b1;
                if (col_valid) begin
                    lane_en = 1'b1;
                    if (last_beat) begin
                        state_d = PE_RESULT;
                    end
                end
            end
            PE_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = PE_IDLE;
                end
            end
            default: state_d = PE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PE_IDLE;
            p       <= '0;
            klat    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                PE_IDLE: begin
                    if (start) begin
                        p    <= '0;
                        klat <= len_clamped;
                    end
                end
                PE_COMPUTE: begin
                    if (col_valid) begin
                        p <= p + P_WIDTH'(1);
                    end
                end
                PE_RESULT: begin
                    if (res_ready) begin
                        p <= '0;
                    end
                end
                default: p <= '0;
            endcase
        end
    end

    // A load coinciding with start lands on the same edge, so the first beat already sees the new row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P; i++) begin
                row_buf[i] <= '0;
            end
        end else if (load_row && (state_q == PE_IDLE)) begin
            for (int i = 0; i < P; i++) begin
                row_buf[i] <= row[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pe_mac_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ACCUM_WIDTH (ACCUM_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (lane_clr),
            .en    (lane_en),
            .in1   (row_buf[p]),
            .in2   (col_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .acc   (total[g*ACCUM_WIDTH +: ACCUM_WIDTH]),
            .err   (err[g])
        );
    end

endmodule

// File: tb/tb_pe_multilane.sv
// Directed bench for pe_multilane with P=8, LANES=4, 16-bit operands, 32-bit accumulators.
// Build with PE_SATURATE_EN defined to expect clamped overflow totals.
`timescale 1ns/1ps
module tb_pe_multilane;

    localparam int P     = 8;
    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int PW    = 3;
    localparam int LW    = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  load_row;
    logic [P*DW-1:0]       row;
    logic                  start;
    logic [LW-1:0]         len;
    logic                  col_valid;
    logic                  col_ready;
    logic [LANES*DW-1:0]   col_data;
    logic [PW-1:0]         p;
    logic                  busy;
    logic                  res_valid;
    logic                  res_ready;
    logic [LANES*AW-1:0]   total;
    logic [LANES-1:0]      err;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic early;

    always #5 clk = ~clk;

    pe_multilane #(
        .P(P), .LANES(LANES), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .P_WIDTH(PW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_row(load_row), .row(row), .start(start), .len(len),
        .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data), .p(p), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .total(total), .err(err)
    );

    task automatic set_row_seq();
        for (int i = 0; i < P; i++) row[i*DW +: DW] = DW'(i + 1);
    endtask

    task automatic set_row_const(input logic [DW-1:0] v);
        for (int i = 0; i < P; i++) row[i*DW +: DW] = v;
    endtask

    task automatic set_col_lanes();
        for (int l = 0; l < LANES; l++) col_data[l*DW +: DW] = DW'(l + 1);
    endtask

    task automatic set_col_const(input logic [DW-1:0] v);
        for (int l = 0; l < LANES; l++) col_data[l*DW +: DW] = v;
    endtask

    task automatic pulse_load();
        load_row = 1'b1;
        @(negedge clk);
        load_row = 1'b0;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = LW'(l);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic feed(input int n, input bit stall);
        int beats = 0;
        int guard = 0;
        early = 1'b0;
        while (beats < n && guard < 200) begin
            col_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (col_valid && col_ready) beats++;
            if (res_valid) early = 1'b1;
            @(negedge clk);
            cyc++;
            guard++;
        end
        col_valid = 1'b0;
        checks++;
        if (beats !== n) begin
            errors++;
            $display("FAIL feed_beats got %0d beats, want %0d", beats, n);
        end
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (col_ready !== 1'b0) begin errors++; $display("FAIL reset_col_ready got %b want 0", col_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        checks++; if (total !== '0)       begin errors++; $display("FAIL reset_total got %h want 0", total); end
        checks++; if (err !== '0)         begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (p !== '0)           begin errors++; $display("FAIL reset_p got %0d want 0", p); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_row_seq();
        pulse_load();
        set_col_lanes();
        do_start(8);
        feed(8, 1'b0);
        checks++;
        if (res_valid !== 1'b1 || cyc !== 9 || early !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency res_valid=%b cyc=%0d early=%b want 1,9,0", res_valid, cyc, early);
        end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (total[l*AW +: AW] !== AW'(36 * (l + 1))) begin
                errors++;
                $display("FAIL basic_total lane%0d got %0d want %0d", l, total[l*AW +: AW], 36 * (l + 1));
            end
        end
        checks++; if (err !== '0) begin errors++; $display("FAIL basic_err got %b want 0", err); end
        accept();
        checks++;
        if (busy !== 1'b0 || p !== '0) begin
            errors++;
            $display("FAIL basic_return_idle busy=%b p=%0d want 0,0", busy, p);
        end
    endtask

    task automatic test_short_len();
        set_col_const(16'd2);
        do_start(3);
        feed(3, 1'b0);
        checks++;
        if (res_valid !== 1'b1 || cyc !== 4) begin
            errors++; $display("FAIL len3_latency res_valid=%b cyc=%0d want 1,4", res_valid, cyc);
        end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (total[l*AW +: AW] !== AW'(12)) begin
                errors++; $display("FAIL len3_total lane%0d got %0d want 12", l, total[l*AW +: AW]);
            end
        end
        accept();

        do_start(0);
        checks++;
        if (res_valid !== 1'b1 || total !== '0 || col_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0 res_valid=%b total=%h col_ready=%b want 1,0,0", res_valid, total, col_ready);
        end
        accept();

        set_col_const(16'd1);
        do_start(12);
        feed(8, 1'b0);
        checks++;
        if (res_valid !== 1'b1 || cyc !== 9 || col_ready !== 1'b0) begin
            errors++;
            $display("FAIL len12_clamp res_valid=%b cyc=%0d col_ready=%b want 1,9,0", res_valid, cyc, col_ready);
        end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (total[l*AW +: AW] !== AW'(36)) begin
                errors++; $display("FAIL len12_total lane%0d got %0d want 36", l, total[l*AW +: AW]);
            end
        end
        accept();
    endtask

    task automatic test_load_with_start();
        set_row_const(16'd3);
        set_col_const(16'd1);
        load_row = 1'b1;
        do_start(2);
        load_row = 1'b0;
        feed(2, 1'b0);
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (total[l*AW +: AW] !== AW'(6)) begin
                errors++; $display("FAIL load_start_total lane%0d got %0d want 6", l, total[l*AW +: AW]);
            end
        end
        accept();
        set_row_seq();
        pulse_load();
    endtask

    task automatic test_handshake();
        logic stable;
        set_col_lanes();
        do_start(8);
        set_row_const(16'd7);
        load_row = 1'b1;
        feed(8, 1'b1);
        load_row = 1'b0;
        set_row_seq();
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            len   = LW'(3);
            if (res_valid !== 1'b1) stable = 1'b0;
            for (int l = 0; l < LANES; l++)
                if (total[l*AW +: AW] !== AW'(36 * (l + 1))) stable = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (stable !== 1'b1) begin
            errors++; $display("FAIL hold_stable got %b want 1", stable);
        end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (total[l*AW +: AW] !== AW'(36 * (l + 1))) begin
                errors++;
                $display("FAIL stall_total lane%0d got %0d want %0d", l, total[l*AW +: AW], 36 * (l + 1));
            end
        end
        accept();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL start_in_result_queued busy=%b want 0", busy);
        end
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL res_ready_idle busy=%b res_valid=%b want 0,0", busy, res_valid);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [AW-1:0] want;
`ifdef PE_SATURATE_EN
        want = 32'h7FFF_FFFF;
`else
        want = 32'h0000_0000;
`endif
        set_row_const(16'h8000);
        pulse_load();
        set_col_const(16'h8000);
        do_start(8);
        feed(8, 1'b0);
        checks++;
        if (err !== 4'hF) begin errors++; $display("FAIL ovf_err got %b want 1111", err); end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (total[l*AW +: AW] !== want) begin
                errors++; $display("FAIL ovf_total lane%0d got %h want %h", l, total[l*AW +: AW], want);
            end
        end
        accept();
        checks++;
        if (err !== 4'hF) begin errors++; $display("FAIL ovf_err_sticky got %b want 1111", err); end
    endtask

    task automatic test_reset_mid();
        set_row_seq();
        pulse_load();
        set_col_lanes();
        do_start(8);
        feed(4, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || col_ready !== 1'b0 || res_valid !== 1'b0 || p !== '0) begin
            errors++;
            $display("FAIL mid_reset_ctrl busy=%b col_ready=%b res_valid=%b p=%0d want 0,0,0,0",
                     busy, col_ready, res_valid, p);
        end
        checks++;
        if (total !== '0 || err !== '0) begin
            errors++; $display("FAIL mid_reset_data total=%h err=%b want 0,0", total, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle res_valid=%b busy=%b want 0,0", res_valid, busy);
        end
        set_col_const(16'd1);
        do_start(2);
        feed(2, 1'b0);
        checks++;
        if (total !== '0) begin errors++; $display("FAIL row_buf_cleared total=%h want 0", total); end
        accept();
        pulse_load();
        set_col_lanes();
        do_start(8);
        feed(8, 1'b0);
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (total[l*AW +: AW] !== AW'(36 * (l + 1))) begin
                errors++;
                $display("FAIL post_reset_total lane%0d got %0d want %0d", l, total[l*AW +: AW], 36 * (l + 1));
            end
        end
        checks++;
        if (err !== '0) begin errors++; $display("FAIL post_reset_err got %b want 0", err); end
        accept();
    endtask

    initial begin
        rst_n     = 1'b0;
        load_row  = 1'b0;
        row       = '0;
        start     = 1'b0;
        len       = '0;
        col_valid = 1'b0;
        col_data  = '0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_short_len();
        test_load_with_start();
        test_handshake();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
